// File: rtl/pds_rr_arbiter.sv
// Round-robin arbiter that shares the single PDS packet input port among NUM_REQ requesters.
// Each grant produces a one-cycle valid_up/ack_o pulse, followed by GAP_CYCLES forced idle cycles.
module pds_rr_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int SRC_W      = 4,
   parameter int TGT_W      = 4,
   parameter int DATA_W     = 8,
   parameter int GAP_CYCLES = 1,
   parameter int CNT_W      = 16,
   localparam int PKT_W     = SRC_W + TGT_W + DATA_W
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       enable,
   input  logic [NUM_REQ-1:0]         req_i,
   input  logic [NUM_REQ*PKT_W-1:0]   pkt_i,
   output logic [NUM_REQ-1:0]         ack_o,
   output logic [PKT_W-1:0]           data_ip,
   output logic                       valid_up,
   output logic                       busy_o,
   output logic [CNT_W-1:0]           pkt_cnt_o
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic {
      IDLE = 1'b0,
      GAP  = 1'b1
   } state_t;

   state_t               state_q, state_d;
   logic [3:0]           gap_q, gap_d;
   logic [IDX_W-1:0]     last_q, last_d;
   logic [NUM_REQ-1:0]   ack_q, ack_d;
   logic [PKT_W-1:0]     data_q, data_d;
   logic                 valid_q, valid_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;

   logic [NUM_REQ-1:0]   eligible;
   logic                 found;
   logic [IDX_W-1:0]     winner;
   logic [IDX_W:0]       idx;

   // A requester acked this cycle is masked so its lingering req cannot win twice.
   always_comb begin
      eligible = req_i & ~ack_q;
      found    = 1'b0;
      winner   = last_q;
      idx      = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = {1'b0, last_q} + (IDX_W+1)'(k);
         if (idx >= (IDX_W+1)'(NUM_REQ)) begin
            idx = idx - (IDX_W+1)'(NUM_REQ);
         end
         if (!found && eligible[idx[IDX_W-1:0]]) begin
            found  = 1'b1;
            winner = idx[IDX_W-1:0];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      gap_d   = gap_q;
      last_d  = last_q;
      ack_d   = '0;
      data_d  = data_q;
      valid_d = 1'b0;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (enable && found) begin
               data_d  = pkt_i[winner*PKT_W +: PKT_W];
               valid_d = 1'b1;
               ack_d   = NUM_REQ'(1) << winner;
               last_d  = winner;
               cnt_d   = cnt_q + CNT_W'(1);
               if (GAP_CYCLES > 0) begin
                  state_d = GAP;
                  gap_d   = 4'(GAP_CYCLES);
               end
            end
         end
         GAP: begin
            if (gap_q <= 4'd1) begin
               state_d = IDLE;
            end
            gap_d = gap_q - 4'd1;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         gap_q   <= '0;
         last_q  <= IDX_W'(NUM_REQ - 1);
         ack_q   <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         gap_q   <= gap_d;
         last_q  <= last_d;
         ack_q   <= ack_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         cnt_q   <= cnt_d;
      end
   end

   assign ack_o     = ack_q;
   assign data_ip   = data_q;
   assign valid_up  = valid_q;
   assign busy_o    = (state_q != IDLE);
   assign pkt_cnt_o = cnt_q;

endmodule
